// File: rtl/biquad_mac_seq_if.sv
// Sample, coefficient and shared-multiplier bundle for biquad_mac_seq.
// sat_flag is present only when BIQUAD_MAC_SEQ_SAT_EN is defined.
interface biquad_mac_seq_if #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16
);
  logic                             hist_clr;
  logic [COEFWIDTH-1:0]             b0;
  logic [COEFWIDTH-1:0]             b1;
  logic [COEFWIDTH-1:0]             b2;
  logic [COEFWIDTH-1:0]             a1;
  logic [COEFWIDTH-1:0]             a2;
  logic [DATAWIDTH-1:0]             din;
  logic                             din_valid;
  logic                             din_ready;
  logic [COEFWIDTH-2:0]             mul_a;
  logic [DATAWIDTH+2:0]             mul_b;
  logic [DATAWIDTH+COEFWIDTH+1:0]   mul_p;
  logic [DATAWIDTH-1:0]             dout;
  logic                             dout_valid;
`ifdef BIQUAD_MAC_SEQ_SAT_EN
  logic                             sat_flag;

  modport slave (
    input  hist_clr, b0, b1, b2, a1, a2,
    input  din, din_valid, mul_p,
    output din_ready, mul_a, mul_b,
    output dout, dout_valid, sat_flag
  );
  modport master (
    output hist_clr, b0, b1, b2, a1, a2,
    output din, din_valid, mul_p,
    input  din_ready, mul_a, mul_b,
    input  dout, dout_valid, sat_flag
  );
`else
  modport slave (
    input  hist_clr, b0, b1, b2, a1, a2,
    input  din, din_valid, mul_p,
    output din_ready, mul_a, mul_b,
    output dout, dout_valid
  );
  modport master (
    output hist_clr, b0, b1, b2, a1, a2,
    output din, din_valid, mul_p,
    input  din_ready, mul_a, mul_b,
    input  dout, dout_valid
  );
`endif
endinterface

// File: rtl/biquad_mac_seq.sv
// Time-multiplexed DF-I biquad controller over one external multiplier.
// BIQUAD_MAC_SEQ_SAT_EN: saturate the output instead of wrapping; adds sat_flag.
module biquad_mac_seq #(
  parameter int DATAWIDTH = 16,
  parameter int COEFWIDTH = 16
) (
  input logic             clk,
  input logic             nreset,
  biquad_mac_seq_if.slave bus
);
  localparam int DW  = DATAWIDTH;
  localparam int CW  = COEFWIDTH;
  localparam int MW  = DW + 3;
  localparam int PW  = DW + CW + 2;
  localparam int AW  = DW + CW + 5;
  localparam int RQW = AW - CW + 2;

  localparam logic signed [AW-1:0] RND =
    {{(AW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};
  localparam logic [CW-2:0] ONE_C = {{(CW-2){1'b0}}, 1'b1};
  localparam logic [DW:0]   ONE_D = {{DW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, MAC} state_t;

  state_t               state_q, state_d;
  logic [2:0]           step_q, step_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic [DW-1:0]        y1_q, y1_d, y2_q, y2_d;
  logic [CW-1:0]        b1_q, b1_d, b2_q, b2_d;
  logic [CW-1:0]        a1_q, a1_d, a2_q, a2_d;
  logic [CW-2:0]        ma_q, ma_d;
  logic [MW-1:0]        mb_q, mb_d;
  logic                 neg_q, neg_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 sat_q, sat_d;

  logic signed [AW-1:0]  ext, sum, rsum;
  logic signed [RQW-1:0] rq;
  logic [DW-1:0]         fit;
  logic                  clip;
  logic [CW-1:0]         nc;
  logic [DW-1:0]         nop;
  logic                  nsub;
  logic                  unused_bits;

  // Most negative coefficient has no positive twin; clamp its magnitude.
  function automatic logic [CW-2:0] mag_c(input logic [CW-1:0] c);
    if (!c[CW-1])
      return c[CW-2:0];
    else if (c[CW-2:0] == '0)
      return '1;
    else
      return ~c[CW-2:0] + ONE_C;
  endfunction

  function automatic logic [MW-1:0] mag_d(input logic [DW-1:0] d);
    logic [DW:0] e;
    e = {d[DW-1], d};
    return {2'b00, d[DW-1] ? (~e + ONE_D) : e};
  endfunction

  always_comb begin
    ext  = {{(AW-PW){1'b0}}, bus.mul_p};
    sum  = neg_q ? acc_q - ext : acc_q + ext;
    rsum = sum + RND;
    rq   = rsum[AW-1:CW-2];
`ifdef BIQUAD_MAC_SEQ_SAT_EN
    clip = 1'b1;
    if (rq > $signed({{(RQW-DW+1){1'b0}}, {(DW-1){1'b1}}}))
      fit = {1'b0, {(DW-1){1'b1}}};
    else if (rq < $signed({{(RQW-DW+1){1'b1}}, {(DW-1){1'b0}}}))
      fit = {1'b1, {(DW-1){1'b0}}};
    else begin
      fit  = rq[DW-1:0];
      clip = 1'b0;
    end
    unused_bits = ^rsum[CW-3:0];
`else
    fit  = rq[DW-1:0];
    clip = 1'b0;
    unused_bits = ^{rsum[CW-3:0], rq[RQW-1:DW]};
`endif
  end

  always_comb begin
    nc   = a2_q;
    nop  = y2_q;
    nsub = 1'b1;
    case (step_q)
      3'd0: begin nc = b1_q; nop = x1_q; nsub = 1'b0; end
      3'd1: begin nc = b2_q; nop = x2_q; nsub = 1'b0; end
      3'd2: begin nc = a1_q; nop = y1_q; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    x0_d = x0_q; x1_d = x1_q; x2_d = x2_q;
    y1_d = y1_q; y2_d = y2_q;
    b1_d = b1_q; b2_d = b2_q;
    a1_d = a1_q; a2_d = a2_q;
    ma_d  = ma_q;
    mb_d  = mb_q;
    neg_d = neg_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    sat_d  = sat_q;
    if (bus.hist_clr) begin
      state_d = IDLE;
      step_d  = '0;
      acc_d   = '0;
      x1_d = '0; x2_d = '0;
      y1_d = '0; y2_d = '0;
      ma_d = '0; mb_d = '0;
      neg_d = 1'b0;
    end else if (state_q == IDLE) begin
      ma_d = '0;
      mb_d = '0;
      if (bus.din_valid) begin
        state_d = MAC;
        step_d  = '0;
        x0_d = bus.din;
        b1_d = bus.b1; b2_d = bus.b2;
        a1_d = bus.a1; a2_d = bus.a2;
        ma_d  = mag_c(bus.b0);
        mb_d  = mag_d(bus.din);
        neg_d = bus.b0[CW-1] ^ bus.din[DW-1];
      end
    end else begin
      acc_d = sum;
      if (step_q == 3'd4) begin
        state_d = IDLE;
        step_d  = '0;
        acc_d   = '0;
        dout_d  = fit;
        dv_d    = 1'b1;
        sat_d   = clip;
        x2_d = x1_q; x1_d = x0_q;
        y2_d = y1_q; y1_d = fit;
        ma_d = '0; mb_d = '0;
        neg_d = 1'b0;
      end else begin
        step_d = step_q + 3'd1;
        ma_d   = mag_c(nc);
        mb_d   = mag_d(nop);
        neg_d  = nc[CW-1] ^ nop[DW-1] ^ nsub;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      x0_q <= '0; x1_q <= '0; x2_q <= '0;
      y1_q <= '0; y2_q <= '0;
      b1_q <= '0; b2_q <= '0;
      a1_q <= '0; a2_q <= '0;
      ma_q  <= '0;
      mb_q  <= '0;
      neg_q <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      x0_q <= x0_d; x1_q <= x1_d; x2_q <= x2_d;
      y1_q <= y1_d; y2_q <= y2_d;
      b1_q <= b1_d; b2_q <= b2_d;
      a1_q <= a1_d; a2_q <= a2_d;
      ma_q  <= ma_d;
      mb_q  <= mb_d;
      neg_q <= neg_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.din_ready  = (state_q == IDLE);
  assign bus.mul_a      = ma_q;
  assign bus.mul_b      = mb_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
`ifdef BIQUAD_MAC_SEQ_SAT_EN
  assign bus.sat_flag   = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif
endmodule

// File: tb/tb_biquad_mac_seq.sv
// Bench for biquad_mac_seq: sample-level filter model plus directed vectors.
// Build with BIQUAD_MAC_SEQ_SAT_EN to exercise the saturating variant.
module tb_biquad_mac_seq;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic nreset = 1'b0;

  biquad_mac_seq_if #(.DATAWIDTH(DW), .COEFWIDTH(CW)) bus();

  biquad_mac_seq #(.DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // External magnitude multiplier, combinational.
  assign bus.mul_p = {{(DW+3){1'b0}}, bus.mul_a} *
                     {{(CW-1){1'b0}}, bus.mul_b};

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  longint cyc = 0;
  bit     pend = 1'b0;
  longint due = 0;
  longint exp_y = 0;
  bit     exp_clip = 1'b0;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  longint mdout = 0;
  bit     mclip = 1'b0;

  task automatic chk(input string name, input longint act,
                     input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d",
               name, act, expv, cyc);
    end
  endtask

  function automatic longint cv(input logic [15:0] c);
    longint v;
    v = longint'($signed(c));
    if (v == -32768) v = -32767;
    return v;
  endfunction

  function automatic longint fitv(input longint r);
    longint w;
`ifdef BIQUAD_MAC_SEQ_SAT_EN
    w = r;
    if (r > 32767) w = 32767;
    if (r < -32768) w = -32768;
`else
    w = r & 64'hFFFF;
    if (w > 32767) w = w - 65536;
`endif
    return w;
  endfunction

  // Sample-level model: one filter evaluation per accepted sample.
  initial forever begin
    bit rdy;
    longint x, s, r;
    @(posedge clk or negedge nreset);
    if (!nreset) begin
      pend = 1'b0;
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      mdout = 0;
      mclip = 1'b0;
    end else begin
      rdy = !(pend && cyc < due);
      cyc++;
      if (bus.hist_clr) begin
        pend = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      end else if (rdy && bus.din_valid) begin
        x = longint'($signed(bus.din));
        s = cv(bus.b0) * x + cv(bus.b1) * mx1 + cv(bus.b2) * mx2
          - cv(bus.a1) * my1 - cv(bus.a2) * my2;
        r = (s + 8192) >>> 14;
        exp_y = fitv(r);
        exp_clip = (exp_y != r);
        mx2 = mx1; mx1 = x;
        my2 = my1; my1 = exp_y;
        pend = 1'b1;
        due = cyc + 5;
      end
    end
  end

  initial forever begin
    bit edv, erdy;
    @(negedge clk);
    edv  = pend && (cyc == due);
    erdy = !(pend && cyc < due);
    if (edv) begin
      mdout = exp_y;
      mclip = exp_clip;
    end
    chk("dout_valid", longint'(bus.dout_valid), longint'(edv));
    chk("din_ready", longint'(bus.din_ready), longint'(erdy));
    chk("dout", longint'($signed(bus.dout)), mdout);
    if (erdy) begin
      chk("mul_a_idle", longint'(bus.mul_a), 0);
      chk("mul_b_idle", longint'(bus.mul_b), 0);
    end
`ifdef BIQUAD_MAC_SEQ_SAT_EN
    if (edv) chk("sat_flag", longint'(bus.sat_flag), longint'(mclip));
`endif
  end

  task automatic setc(input int b0, input int b1, input int b2,
                      input int a1, input int a2);
    bus.b0 = 16'(b0); bus.b1 = 16'(b1); bus.b2 = 16'(b2);
    bus.a1 = 16'(a1); bus.a2 = 16'(a2);
  endtask

  task automatic clr();
    @(negedge clk);
    bus.hist_clr = 1'b1;
    @(negedge clk);
    bus.hist_clr = 1'b0;
  endtask

  task automatic send(input int d);
    @(negedge clk);
    bus.din = 16'(d);
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input int val, input int lat);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if (bus.dout_valid) begin
        got = 1'b1;
        n = i;
      end
    end
    chk({name, "_seen"}, longint'(got), 1);
    if (got) begin
      chk(name, longint'($signed(bus.dout)), val);
      chk({name, "_model"}, exp_y, val);
      if (lat > 0) chk({name, "_latency"}, n, lat);
    end
  endtask

  task automatic count_dv(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.dout_valid) cnt++;
    end
  endtask

  initial begin
    int cnt;
    bus.hist_clr = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    setc(0, 0, 0, 0, 0);
    #1;
    chk("rst_dout_valid", longint'(bus.dout_valid), 0);
    chk("rst_din_ready", longint'(bus.din_ready), 1);
    chk("rst_dout", longint'(bus.dout), 0);
    chk("rst_mul_a", longint'(bus.mul_a), 0);
    chk("rst_mul_b", longint'(bus.mul_b), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    setc(16384, 0, 0, 0, 0);
    clr();
    send(1000);
    wait_out("t1_unity", 1000, 5);

    setc(8192, 8192, 0, 0, 0);
    clr();
    @(negedge clk);
    bus.din = 16'd1000;
    bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din = 16'd3000;
    wait_out("t2_first", 500, 5);
    @(negedge clk);
    bus.din_valid = 1'b0;
    wait_out("t2_second", 2000, 5);

    setc(16384, 0, 0, -8192, 0);
    clr();
    send(1000); wait_out("t3_y0", 1000, 5);
    send(0);    wait_out("t3_y1", 500, 5);
    send(0);    wait_out("t3_y2", 250, 5);
    send(0);    wait_out("t3_y3", 125, 5);
    send(0);    wait_out("t3_y4", 63, 5);

    setc(32767, 0, 0, 0, 0);
    clr();
    send(30000);
`ifdef BIQUAD_MAC_SEQ_SAT_EN
    wait_out("t4_sat", 32767, 5);
    chk("t4_sat_flag", longint'(bus.sat_flag), 1);
`else
    wait_out("t4_wrap", -5538, 5);
`endif

    setc(16384, 0, 0, 0, 0);
    clr();
    @(negedge clk);
    bus.din = 16'd7;
    bus.din_valid = 1'b1;
    count_dv(19, cnt);
    chk("t5_held_count", cnt, 3);
    bus.din_valid = 1'b0;
    wait_out("t5_held_tail", 7, 0);

    setc(16384, 8192, 0, 0, 0);
    clr();
    send(1000);
    wait_out("t5_prime", 1000, 5);
    send(2000);
    repeat (2) @(negedge clk);
    bus.hist_clr = 1'b1;
    @(negedge clk);
    bus.hist_clr = 1'b0;
    count_dv(6, cnt);
    chk("t5_abort_no_valid", cnt, 0);
    send(400);
    wait_out("t5_after_clr", 400, 5);

    setc(16384, 0, 0, -8192, 0);
    clr();
    send(1000);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("t6_rst_dout_valid", longint'(bus.dout_valid), 0);
    chk("t6_rst_din_ready", longint'(bus.din_ready), 1);
    chk("t6_rst_dout", longint'(bus.dout), 0);
    chk("t6_rst_mul_a", longint'(bus.mul_a), 0);
    chk("t6_rst_mul_b", longint'(bus.mul_b), 0);
    @(negedge clk);
    #2 nreset = 1'b1;
    setc(16384, 0, 0, 0, 0);
    send(1000);
    wait_out("t6_repeat", 1000, 5);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
